// File: rtl/control_unit_mw.sv
// Fetch/execute sequencer for the accumulator CPU with memory wait states,
// HALT/Run handling and a sticky illegal-opcode trap.
module control_unit_mw #(
    parameter int OP_W    = 3,
    parameter int STATE_W = 5
) (
    input  logic               CLK,
    input  logic               RSTn,
    input  logic [OP_W-1:0]    IR,
    input  logic               Z,
    input  logic               MemReady,
    input  logic               Run,
    output logic               ARLoad,
    output logic               DRLoad,
    output logic               PCLoad,
    output logic               ACLoad,
    output logic               IRLoad,
    output logic               PCInc,
    output logic               memRW,
    output logic [1:0]         ALUSel,
    output logic [1:0]         BusSel,
    output logic [STATE_W-1:0] state,
    output logic               Halted,
    output logic               Illegal
);

    localparam logic [STATE_W-1:0] LOAD1  = STATE_W'(0);
    localparam logic [STATE_W-1:0] LOAD2  = STATE_W'(1);
    localparam logic [STATE_W-1:0] STORE1 = STATE_W'(2);
    localparam logic [STATE_W-1:0] STORE2 = STATE_W'(3);
    localparam logic [STATE_W-1:0] ADD1   = STATE_W'(4);
    localparam logic [STATE_W-1:0] ADD2   = STATE_W'(5);
    localparam logic [STATE_W-1:0] SUB1   = STATE_W'(6);
    localparam logic [STATE_W-1:0] SUB2   = STATE_W'(7);
    localparam logic [STATE_W-1:0] JUMP   = STATE_W'(8);
    localparam logic [STATE_W-1:0] JEQ    = STATE_W'(10);
    localparam logic [STATE_W-1:0] FETCH1 = STATE_W'(12);
    localparam logic [STATE_W-1:0] FETCH2 = STATE_W'(13);
    localparam logic [STATE_W-1:0] FETCH3 = STATE_W'(14);
    localparam logic [STATE_W-1:0] AND1   = STATE_W'(16);
    localparam logic [STATE_W-1:0] AND2   = STATE_W'(17);
    localparam logic [STATE_W-1:0] HALT   = STATE_W'(18);

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_n;
    logic               illegal_q;
    logic               illegal_op;

    // Any opcode bit above the low three marks an opcode >= 8.
    assign illegal_op = (IR >> 3) != '0;

    always_ff @(negedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q   <= FETCH1;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_n;
            if (state_q == FETCH3 && illegal_op) begin
                illegal_q <= 1'b1;
            end
        end
    end

    assign state   = state_q;
    assign Illegal = illegal_q;
    assign Halted  = (state_q == HALT);

    always_comb begin
        ARLoad  = 1'b0;
        DRLoad  = 1'b0;
        PCLoad  = 1'b0;
        ACLoad  = 1'b0;
        IRLoad  = 1'b0;
        PCInc   = 1'b0;
        memRW   = 1'b0;
        ALUSel  = 2'd0;
        BusSel  = 2'd0;
        state_n = FETCH1;
        case (state_q)
            FETCH1: begin
                ARLoad  = 1'b1;
                BusSel  = 2'd2;
                state_n = FETCH2;
            end
            FETCH2: begin
                DRLoad  = 1'b1;
                PCInc   = MemReady;
                state_n = MemReady ? FETCH3 : FETCH2;
            end
            FETCH3: begin
                ARLoad = 1'b1;
                IRLoad = 1'b1;
                BusSel = 2'd1;
                if (illegal_op) begin
                    state_n = HALT;
                end else begin
                    case (IR[2:0])
                        3'd0:    state_n = LOAD1;
                        3'd1:    state_n = STORE1;
                        3'd2:    state_n = ADD1;
                        3'd3:    state_n = SUB1;
                        3'd4:    state_n = JUMP;
                        3'd5:    state_n = JEQ;
                        3'd6:    state_n = AND1;
                        default: state_n = HALT;
                    endcase
                end
            end
            LOAD1, ADD1, SUB1, AND1: begin
                DRLoad = 1'b1;
                if (!MemReady) begin
                    state_n = state_q;
                end else begin
                    case (state_q)
                        LOAD1:   state_n = LOAD2;
                        ADD1:    state_n = ADD2;
                        SUB1:    state_n = SUB2;
                        default: state_n = AND2;
                    endcase
                end
            end
            LOAD2: begin
                ACLoad = 1'b1;
                BusSel = 2'd1;
                ALUSel = 2'd3;
            end
            ADD2: begin
                ACLoad = 1'b1;
                BusSel = 2'd1;
                ALUSel = 2'd0;
            end
            SUB2: begin
                ACLoad = 1'b1;
                BusSel = 2'd1;
                ALUSel = 2'd1;
            end
            AND2: begin
                ACLoad = 1'b1;
                BusSel = 2'd1;
                ALUSel = 2'd2;
            end
            STORE1: begin
                DRLoad  = 1'b1;
                BusSel  = 2'd3;
                state_n = STORE2;
            end
            STORE2: begin
                memRW   = 1'b1;
                BusSel  = 2'd1;
                state_n = MemReady ? FETCH1 : STORE2;
            end
            JUMP: begin
                PCLoad = 1'b1;
                BusSel = 2'd1;
            end
            JEQ: begin
                PCLoad = Z;
                BusSel = 2'd1;
            end
            HALT: begin
                state_n = Run ? FETCH1 : HALT;
            end
            // Unused encodings drive nothing and fall back to FETCH1.
            default: begin
                state_n = FETCH1;
            end
        endcase
    end

endmodule

// File: tb/tb_control_unit_mw.sv
// Scoreboard bench for control_unit_mw: a stimulus queue per scenario, expected
// state/output words pushed when inputs are driven and popped for comparison.
module tb_control_unit_mw;

    logic       CLK = 1'b0;
    logic       RSTn = 1'b0;
    logic [3:0] IR = 4'd0;
    logic       Z = 1'b0;
    logic       MemReady = 1'b1;
    logic       Run = 1'b0;
    logic       ARLoad, DRLoad, PCLoad, ACLoad, IRLoad, PCInc, memRW;
    logic [1:0] ALUSel, BusSel;
    logic [4:0] state;
    logic       Halted, Illegal;

    control_unit_mw #(.OP_W(4), .STATE_W(5)) dut (
        .CLK(CLK), .RSTn(RSTn), .IR(IR), .Z(Z), .MemReady(MemReady), .Run(Run),
        .ARLoad(ARLoad), .DRLoad(DRLoad), .PCLoad(PCLoad), .ACLoad(ACLoad),
        .IRLoad(IRLoad), .PCInc(PCInc), .memRW(memRW), .ALUSel(ALUSel),
        .BusSel(BusSel), .state(state), .Halted(Halted), .Illegal(Illegal)
    );

    always #5 CLK = ~CLK;

    logic [12:0] outs;
    assign outs = {ARLoad, DRLoad, PCLoad, ACLoad, IRLoad, PCInc, memRW,
                   ALUSel, BusSel, Halted, Illegal};

    typedef struct {
        logic [3:0]  ir;
        logic        z, mr, run;
        logic [4:0]  st;
        logic [12:0] o;
    } stim_t;

    typedef struct {
        logic [4:0]  st;
        logic [12:0] o;
    } exp_t;

    stim_t stim_q[$];
    exp_t  exp_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    function automatic logic [12:0] ov(input logic ar, dr, pc, ac, irl, inc, rw,
                                       input logic [1:0] alu, bus,
                                       input logic h, il);
        return {ar, dr, pc, ac, irl, inc, rw, alu, bus, h, il};
    endfunction

    // Expected output words per state (Illegal bit clear).
    function automatic logic [12:0] o_f1();            return ov(1,0,0,0,0,0,0,2'd0,2'd2,0,0); endfunction
    function automatic logic [12:0] o_f2(input logic i); return ov(0,1,0,0,0,i,0,2'd0,2'd0,0,0); endfunction
    function automatic logic [12:0] o_f3();            return ov(1,0,0,0,1,0,0,2'd0,2'd1,0,0); endfunction
    function automatic logic [12:0] o_mem();           return ov(0,1,0,0,0,0,0,2'd0,2'd0,0,0); endfunction
    function automatic logic [12:0] o_alu(input logic [1:0] a); return ov(0,0,0,1,0,0,0,a,2'd1,0,0); endfunction
    function automatic logic [12:0] o_st1();           return ov(0,1,0,0,0,0,0,2'd0,2'd3,0,0); endfunction
    function automatic logic [12:0] o_st2();           return ov(0,0,0,0,0,0,1,2'd0,2'd1,0,0); endfunction
    function automatic logic [12:0] o_jmp(input logic p); return ov(0,0,p,0,0,0,0,2'd0,2'd1,0,0); endfunction
    function automatic logic [12:0] o_halt();          return ov(0,0,0,0,0,0,0,2'd0,2'd0,1,0); endfunction

    task automatic add(input logic [3:0] ir, input logic z, mr, run,
                       input logic [4:0] st, input logic [12:0] o);
        stim_t s;
        s.ir = ir; s.z = z; s.mr = mr; s.run = run; s.st = st; s.o = o;
        stim_q.push_back(s);
    endtask

    task automatic apply(input stim_t s);
        exp_t e;
        IR = s.ir; Z = s.z; MemReady = s.mr; Run = s.run;
        e.st = s.st; e.o = s.o;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        exp_t e;
        IR = 4'd2; MemReady = 1'b0; Run = 1'b1; Z = 1'b1;
        apply('{ir: 4'd2, z: 1'b1, mr: 1'b0, run: 1'b1, st: 5'd12, o: o_f1()});
        @(negedge CLK); @(negedge CLK); #1;
        e = exp_q.pop_front();
        n_tests++;
        if ({state, outs} !== {e.st, e.o}) begin
            n_fail++;
            $display("FAIL reset: got st=%0d out=%b, want st=%0d out=%b", state, outs, e.st, e.o);
        end
        RSTn = 1'b1;
    endtask

    task automatic test_fetch_load();
        stim_t s;
        exp_t  e;
        int    k = 0;
        add(0,0,1,0, 12, o_f1());
        add(0,0,1,0, 13, o_f2(1));
        add(0,0,1,0, 14, o_f3());
        add(0,0,1,0, 0,  o_mem());
        add(0,0,1,0, 1,  o_alu(2'd3));
        add(0,0,1,0, 12, o_f1());
        add(0,0,0,0, 13, o_f2(0));
        add(0,0,0,0, 13, o_f2(0));
        add(0,0,0,0, 13, o_f2(0));
        add(0,0,1,0, 13, o_f2(1));
        add(0,0,1,0, 14, o_f3());
        add(0,0,1,0, 0,  o_mem());
        add(0,0,1,0, 1,  o_alu(2'd3));
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            apply(s);
            #1;
            e = exp_q.pop_front();
            n_tests++;
            if ({state, outs} !== {e.st, e.o}) begin
                n_fail++;
                $display("FAIL fetch_load[%0d]: got st=%0d out=%b, want st=%0d out=%b", k, state, outs, e.st, e.o);
            end
            k++;
            @(negedge CLK); #1;
        end
    endtask

    task automatic test_store();
        stim_t s;
        exp_t  e;
        int    k = 0;
        add(1,0,1,0, 12, o_f1());
        add(1,0,1,0, 13, o_f2(1));
        add(1,0,1,0, 14, o_f3());
        add(1,0,0,0, 2,  o_st1());
        add(1,0,0,0, 3,  o_st2());
        add(1,0,0,0, 3,  o_st2());
        add(1,0,1,0, 3,  o_st2());
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            apply(s);
            #1;
            e = exp_q.pop_front();
            n_tests++;
            if ({state, outs} !== {e.st, e.o}) begin
                n_fail++;
                $display("FAIL store[%0d]: got st=%0d out=%b, want st=%0d out=%b", k, state, outs, e.st, e.o);
            end
            k++;
            @(negedge CLK); #1;
        end
    endtask

    task automatic test_jumps();
        stim_t s;
        exp_t  e;
        int    k = 0;
        add(5,0,1,0, 12, o_f1());
        add(5,0,1,0, 13, o_f2(1));
        add(5,0,1,0, 14, o_f3());
        add(5,0,1,0, 10, o_jmp(0));
        add(5,1,1,0, 12, o_f1());
        add(5,1,1,0, 13, o_f2(1));
        add(5,1,1,0, 14, o_f3());
        add(5,1,1,0, 10, o_jmp(1));
        add(4,0,1,0, 12, o_f1());
        add(4,0,1,0, 13, o_f2(1));
        add(4,0,1,0, 14, o_f3());
        add(4,0,1,0, 8,  o_jmp(1));
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            apply(s);
            #1;
            e = exp_q.pop_front();
            n_tests++;
            if ({state, outs} !== {e.st, e.o}) begin
                n_fail++;
                $display("FAIL jumps[%0d]: got st=%0d out=%b, want st=%0d out=%b", k, state, outs, e.st, e.o);
            end
            k++;
            @(negedge CLK); #1;
        end
    endtask

    task automatic test_alu_halt();
        stim_t s;
        exp_t  e;
        int    k = 0;
        add(2,0,1,0, 12, o_f1());
        add(2,0,1,0, 13, o_f2(1));
        add(2,0,1,0, 14, o_f3());
        add(2,0,0,0, 4,  o_mem());
        add(2,0,1,0, 4,  o_mem());
        add(2,0,1,0, 5,  o_alu(2'd0));
        add(3,0,1,0, 12, o_f1());
        add(3,0,1,0, 13, o_f2(1));
        add(3,0,1,0, 14, o_f3());
        add(3,0,1,0, 6,  o_mem());
        add(3,0,1,0, 7,  o_alu(2'd1));
        add(6,0,1,0, 12, o_f1());
        add(6,0,1,0, 13, o_f2(1));
        add(6,0,1,0, 14, o_f3());
        add(6,0,1,0, 16, o_mem());
        add(6,0,1,0, 17, o_alu(2'd2));
        add(7,0,1,0, 12, o_f1());
        add(7,0,1,0, 13, o_f2(1));
        add(7,0,1,0, 14, o_f3());
        add(7,0,1,0, 18, o_halt());
        add(7,0,1,0, 18, o_halt());
        add(7,0,1,1, 18, o_halt());
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            apply(s);
            #1;
            e = exp_q.pop_front();
            n_tests++;
            if ({state, outs} !== {e.st, e.o}) begin
                n_fail++;
                $display("FAIL alu_halt[%0d]: got st=%0d out=%b, want st=%0d out=%b", k, state, outs, e.st, e.o);
            end
            k++;
            @(negedge CLK); #1;
        end
        Run = 1'b0;
    endtask

    task automatic test_illegal();
        stim_t s;
        exp_t  e;
        int    k = 0;
        add(9,0,1,0, 12, o_f1());
        add(9,0,1,0, 13, o_f2(1));
        add(9,0,1,0, 14, o_f3());
        add(9,0,1,0, 18, o_halt() | 13'd1);
        add(9,0,1,1, 18, o_halt() | 13'd1);
        add(2,0,1,0, 12, o_f1() | 13'd1);
        add(2,0,1,0, 13, o_f2(1) | 13'd1);
        add(2,0,1,0, 14, o_f3() | 13'd1);
        add(2,0,0,0, 4,  o_mem() | 13'd1);
        add(2,0,0,0, 4,  o_mem() | 13'd1);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            apply(s);
            #1;
            e = exp_q.pop_front();
            n_tests++;
            if ({state, outs} !== {e.st, e.o}) begin
                n_fail++;
                $display("FAIL illegal[%0d]: got st=%0d out=%b, want st=%0d out=%b", k, state, outs, e.st, e.o);
            end
            k++;
            if (stim_q.size() > 0) begin
                @(negedge CLK); #1;
            end
        end
        // Asynchronous reset while still stalled in ADD1, well away from the edge.
        #1 RSTn = 1'b0;
        apply('{ir: 4'd2, z: 1'b0, mr: 1'b0, run: 1'b0, st: 5'd12, o: o_f1()});
        #1;
        e = exp_q.pop_front();
        n_tests++;
        if ({state, outs} !== {e.st, e.o}) begin
            n_fail++;
            $display("FAIL async_reset: got st=%0d out=%b, want st=%0d out=%b", state, outs, e.st, e.o);
        end
        #1 RSTn = 1'b1;
        apply('{ir: 4'd2, z: 1'b0, mr: 1'b1, run: 1'b0, st: 5'd13, o: o_f2(1)});
        @(negedge CLK); #1;
        e = exp_q.pop_front();
        n_tests++;
        if ({state, outs} !== {e.st, e.o}) begin
            n_fail++;
            $display("FAIL after_reset: got st=%0d out=%b, want st=%0d out=%b", state, outs, e.st, e.o);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_fetch_load();
        test_store();
        test_jumps();
        test_alu_halt();
        test_illegal();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
